ring_output_arbiter: RTL and testbench

// - Arbiter/sequencer for one ring output port (CW or CCW) of the cardinal router.
// - Shares the port between through-traffic and PE injection, with one 1-deep buffer per virtual channel (VC0 even, VC1 odd).
// - Generates the even/odd polarity and drives the output link from the VC that matches polarity.
// - One instance per ring direction; req0 is ring through-traffic, req1 is PE injection.

---
 rtl/ring_output_arbiter_if.sv | 36 +++
 rtl/ring_output_arbiter.sv | 126 ++++++++++++
 tb/tb_ring_output_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_output_arbiter_if.sv
// Interface: ring_output_arbiter_if
// Request/grant handshakes for through-traffic (req0) and PE injection (req1), plus the output link.
interface ring_output_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req0_vld;
    logic              req0_vc;
    logic [DATA_W-1:0] req0_data;
    logic              req0_gnt;
    logic              req1_vld;
    logic              req1_vc;
    logic [DATA_W-1:0] req1_data;
    logic              req1_gnt;
    logic              so;
    // 'do' is a reserved word in SystemVerilog, so the link data is carried as do_data
    logic [DATA_W-1:0] do_data;
    logic              ro;

    modport slave (
        input  req0_vld, req0_vc, req0_data,
        output req0_gnt,
        input  req1_vld, req1_vc, req1_data,
        output req1_gnt,
        output so, do_data,
        input  ro
    );

    modport master (
        output req0_vld, req0_vc, req0_data,
        input  req0_gnt,
        output req1_vld, req1_vc, req1_data,
        input  req1_gnt,
        input  so, do_data,
        output ro
    );
endinterface

// File: rtl/ring_output_arbiter.sv
// Module: ring_output_arbiter -- shares one ring output port between through-traffic and PE injection
// with a 1-deep buffer per VC. Optional blocked-request counter under macro RING_ARB_STATS_EN.
module ring_output_arbiter #(
    parameter int DATA_W  = 64,
    parameter int HOP_LSB = 18,
    parameter int HOP_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 polarity,
    ring_output_arbiter_if.slave bus,
    output logic [15:0]          stall_cnt
);

    logic              polarity_r;
    logic [1:0]        buf_full_r;
    logic [DATA_W-1:0] buf_data_r [2];
    logic [1:0]        rr_r;
    logic              so_r;
    logic [DATA_W-1:0] do_r;

    logic              wr_vc_s;
    logic              send_s;
    logic              elig0_s;
    logic              elig1_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic [DATA_W-1:0] wr_data_s;

    function automatic logic [DATA_W-1:0] hop_halve(input logic [DATA_W-1:0] flit);
        logic [DATA_W-1:0] res;
        res = flit;
        res[HOP_LSB +: HOP_W] = flit[HOP_LSB +: HOP_W] >> 1'b1;
        return res;
    endfunction

    // Eligibility and round-robin grant for the writable VC (the one opposite the current polarity).
    always_comb begin
        wr_vc_s = ~polarity_r;
        send_s  = buf_full_r[polarity_r] & bus.ro;
        elig0_s = reset & bus.req0_vld & (bus.req0_vc == wr_vc_s) & ~buf_full_r[wr_vc_s];
        elig1_s = reset & bus.req1_vld & (bus.req1_vc == wr_vc_s) & ~buf_full_r[wr_vc_s];
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (elig0_s && elig1_s) begin
            if (rr_r[wr_vc_s]) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
        if (gnt1_s) begin
            wr_data_s = hop_halve(bus.req1_data);
        end else begin
            wr_data_s = hop_halve(bus.req0_data);
        end
    end

    // Polarity generator and output link register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_r <= 1'b0;
            so_r       <= 1'b0;
            do_r       <= {DATA_W{1'b0}};
        end else begin
            polarity_r <= ~polarity_r;
            so_r       <= send_s;
            if (send_s) begin
                do_r <= buf_data_r[polarity_r];
            end
        end
    end

    // VC buffers and round-robin pointers; the pointer always moves to the requester not granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full_r    <= 2'b00;
            buf_data_r[0] <= {DATA_W{1'b0}};
            buf_data_r[1] <= {DATA_W{1'b0}};
            rr_r          <= 2'b00;
        end else begin
            if (send_s) begin
                buf_full_r[polarity_r] <= 1'b0;
            end
            if (gnt0_s || gnt1_s) begin
                buf_full_r[wr_vc_s] <= 1'b1;
                buf_data_r[wr_vc_s] <= wr_data_s;
                rr_r[wr_vc_s]       <= gnt0_s;
            end
        end
    end

`ifdef RING_ARB_STATS_EN
    logic [15:0] stall_cnt_r;
    logic        stall_s;

    assign stall_s = (bus.req0_vld & ~gnt0_s) | (bus.req1_vld & ~gnt1_s);

    // Saturating count of cycles with at least one blocked request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign polarity     = polarity_r;
    assign bus.req0_gnt = gnt0_s;
    assign bus.req1_gnt = gnt1_s;
    assign bus.so       = so_r;
    assign bus.do_data  = do_r;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Directed bench for ring_output_arbiter: expected link flits go through a scoreboard queue,
// polarity, grants and stall count come from a small bench-side model.
module tb_ring_output_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic [15:0] stall_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        p_m;
    logic [15:0] stall_m;
    logic [63:0] last_do;
    logic [63:0] sb [$];
    logic [63:0] d;

    ring_output_arbiter_if #(.DATA_W(64)) bus_if ();

    ring_output_arbiter #(.DATA_W(64), .HOP_LSB(18), .HOP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .bus       (bus_if),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // hop field is bits 25:18; halving it shifts those eight bits right by one
    function automatic logic [63:0] exp_flit(input logic [63:0] f);
        return {f[63:26], 1'b0, f[25:19], f[17:0]};
    endfunction

    task automatic cmp(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: grants/polarity checked before the edge, link and stall count just after it.
    task automatic cycle(input string tag, input logic eg0, input logic eg1, input logic eso);
        logic [63:0] exp_do;
        @(negedge clk);
        cmp({tag, ".pol"},  64'(polarity), 64'(p_m));
        cmp({tag, ".gnt0"}, 64'(bus_if.req0_gnt), 64'(eg0));
        cmp({tag, ".gnt1"}, 64'(bus_if.req1_gnt), 64'(eg1));
        if (eg0) sb.push_back(exp_flit(bus_if.req0_data));
        if (eg1) sb.push_back(exp_flit(bus_if.req1_data));
`ifdef RING_ARB_STATS_EN
        if (((bus_if.req0_vld && !eg0) || (bus_if.req1_vld && !eg1)) && (stall_m != 16'hFFFF))
            stall_m = stall_m + 16'd1;
`endif
        @(posedge clk);
        #1;
        p_m = ~p_m;
        cmp({tag, ".so"}, 64'(bus_if.so), 64'(eso));
        if (eso) begin
            vectors++;
            assert (sb.size() != 0)
            else begin
                miscompares++;
                $error("FAIL %s.sb: observed flit %h, expected a queued flit", tag, bus_if.do_data);
            end
            if (sb.size() != 0) begin
                exp_do = sb.pop_front();
                cmp({tag, ".do"}, bus_if.do_data, exp_do);
                last_do = exp_do;
            end
        end else begin
            cmp({tag, ".do_hold"}, bus_if.do_data, last_do);
        end
        cmp({tag, ".stall"}, 64'(stall_cnt), 64'(stall_m));
    endtask

    initial begin
        reset   = 1'b0;
        p_m     = 1'b0;
        stall_m = 16'h0000;
        last_do = 64'h0;
        bus_if.req0_vld  = 1'b0;
        bus_if.req0_vc   = 1'b0;
        bus_if.req0_data = 64'h0;
        bus_if.req1_data = 64'h0;
        bus_if.ro        = 1'b1;
        // a request that would be eligible at polarity 0 must not be granted in reset
        bus_if.req1_vld  = 1'b1;
        bus_if.req1_vc   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst.pol",   64'(polarity), 64'd0);
        cmp("rst.so",    64'(bus_if.so), 64'd0);
        cmp("rst.do",    bus_if.do_data, 64'd0);
        cmp("rst.gnt1",  64'(bus_if.req1_gnt), 64'd0);
        cmp("rst.stall", 64'(stall_cnt), 64'd0);
        bus_if.req1_vld = 1'b0;
        bus_if.req1_vc  = 1'b0;
        reset = 1'b1;

        repeat (4) cycle("idle", 1'b0, 1'b0, 1'b0);

        // injection at P=0 into VC1, hop 6 -> 3, sent one cycle later
        d = 64'hDEAD_BEEF_CAFE_F00D;
        d[25:18] = 8'b0000_0110;
        bus_if.req1_data = d;
        bus_if.req1_vc   = 1'b1;
        bus_if.req1_vld  = 1'b1;
        cycle("inj", 1'b0, 1'b1, 1'b0);
        bus_if.req1_vld = 1'b0;
        cycle("inj_out", 1'b0, 1'b0, 1'b1);
        cmp("inj.hop",  64'(bus_if.do_data[25:18]), 64'd3);
        cmp("inj.rest", {8'h00, bus_if.do_data[63:26], bus_if.do_data[17:0]}, {8'h00, d[63:26], d[17:0]});
        cycle("gap", 1'b0, 1'b0, 1'b0);

        // both requesters on VC0 at P=1 with rr[0]=0: req0 first, req1 two cycles later
        bus_if.req0_data = 64'h0123_4567_89AB_CDEF;
        bus_if.req0_vc   = 1'b0;
        bus_if.req0_vld  = 1'b1;
        bus_if.req1_data = 64'hFEDC_BA98_7654_3210;
        bus_if.req1_vc   = 1'b0;
        bus_if.req1_vld  = 1'b1;
        cycle("arb0", 1'b1, 1'b0, 1'b0);
        bus_if.req0_vld = 1'b0;
        cycle("arb1", 1'b0, 1'b0, 1'b1);
        cycle("arb2", 1'b0, 1'b1, 1'b0);
        bus_if.req1_vld = 1'b0;
        cycle("arb3", 1'b0, 1'b0, 1'b1);

        // vc==P is refused, granted next cycle; max hop 8'hFF halves to 8'h7F
        bus_if.req0_data = 64'h0000_0000_03FC_0000;
        bus_if.req0_vc   = 1'b1;
        bus_if.req0_vld  = 1'b1;
        cycle("vcp0", 1'b0, 1'b0, 1'b0);
        cycle("vcp1", 1'b1, 1'b0, 1'b0);
        bus_if.req0_vld = 1'b0;

        // downstream not ready: buf[1] held, VC1 closed to new grants until it drains
        bus_if.ro        = 1'b0;
        bus_if.req1_data = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_if.req1_vc   = 1'b1;
        bus_if.req1_vld  = 1'b1;
        cycle("ro0a", 1'b0, 1'b0, 1'b0);
        cycle("ro0b", 1'b0, 1'b0, 1'b0);
        bus_if.ro = 1'b1;
        cycle("ro1", 1'b0, 1'b0, 1'b1);
        cycle("ro_after", 1'b0, 1'b1, 1'b0);
        bus_if.req1_vld = 1'b0;
        cycle("ro_drain", 1'b0, 1'b0, 1'b1);

        // a lone req0 grant on VC1 hands priority to req1 for the next contest
        bus_if.req0_data = 64'h5555_5555_5555_5555;
        bus_if.req0_vc   = 1'b1;
        bus_if.req0_vld  = 1'b1;
        cycle("rr_a", 1'b1, 1'b0, 1'b0);
        bus_if.req0_vld = 1'b0;
        cycle("rr_b", 1'b0, 1'b0, 1'b1);
        bus_if.req0_data = 64'hAAAA_AAAA_AAAA_AAAA;
        bus_if.req0_vld  = 1'b1;
        bus_if.req1_data = 64'h0F0F_0F0F_0F0F_0F0F;
        bus_if.req1_vc   = 1'b1;
        bus_if.req1_vld  = 1'b1;
        cycle("rr_c", 1'b0, 1'b1, 1'b0);
        bus_if.req1_vld = 1'b0;
        cycle("rr_d", 1'b0, 1'b0, 1'b1);
        cycle("rr_e", 1'b1, 1'b0, 1'b0);
        bus_if.req0_vld = 1'b0;
        cycle("rr_f", 1'b0, 1'b0, 1'b1);

        // reset while so=1 and buf[0] full (hop 1 -> 0 on the flit that goes out)
        bus_if.req0_data = 64'h1234_0000_0004_5678;
        bus_if.req0_vc   = 1'b1;
        bus_if.req0_vld  = 1'b1;
        cycle("rst_a", 1'b1, 1'b0, 1'b0);
        bus_if.req0_vld  = 1'b0;
        bus_if.req1_data = 64'hCAFE_0000_0000_BABE;
        bus_if.req1_vc   = 1'b0;
        bus_if.req1_vld  = 1'b1;
        cycle("rst_b", 1'b0, 1'b1, 1'b1);
        bus_if.req1_vld = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        cmp("mid_rst.so",    64'(bus_if.so), 64'd0);
        cmp("mid_rst.do",    bus_if.do_data, 64'd0);
        cmp("mid_rst.pol",   64'(polarity), 64'd0);
        cmp("mid_rst.stall", 64'(stall_cnt), 64'd0);
        sb.delete();
        last_do = 64'h0;
        stall_m = 16'h0000;
        p_m     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) cycle("post_rst", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
